apb_master_bridge: RTL and testbench

//  Upstream stage of the APB slave memory: converts a simple valid/ready command

---
 rtl/apb_master_bridge_pkg.sv | 14 +
 rtl/apb_master_bridge_if.sv | 27 ++
 rtl/apb_master_bridge_wait_timer.sv | 28 ++
 rtl/apb_master_bridge.sv | 110 +++++++++++
 tb/tb_apb_master_bridge.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge_pkg.sv
// apb_pkg: shared types and default widths for the APB master bridge.
//  APB_ADDR_WIDTH / APB_DATA_WIDTH : default address / data widths
//  state_t                         : bridge FSM states
//  rsp_t                           : registered response {rdata, err, timeout}
package apb_pkg;
   localparam int APB_ADDR_WIDTH = 8;
   localparam int APB_DATA_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   typedef struct packed {
      logic [APB_DATA_WIDTH-1:0] rdata;
      logic                      err;
      logic                      timeout;
   } rsp_t;
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: APB4 bus between the bridge (master) and a completer (slave).
//  PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB : master -> slave
//  PRDATA/PREADY/PSLVERR                  : slave -> master
interface apb_master_bridge_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH = APB_DATA_WIDTH
);
   logic                    PSEL;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [ADDR_WIDTH-1:0]   PADDR;
   logic [DATA_WIDTH-1:0]   PWDATA;
   logic [DATA_WIDTH/8-1:0] PSTRB;
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;
   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );
   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// apb_wait_timer: counts ACCESS wait cycles and flags the last allowed one.
//  PCLK, PRESETn : clock, async active-low reset
//  clear         : zero the counter (asserted in the cycle before ACCESS)
//  enable        : count this cycle (asserted while in ACCESS)
//  expired       : this is ACCESS cycle number TIMEOUT; never set when TIMEOUT=0
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
   localparam logic [W-1:0] LAST  = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   logic [W-1:0] cnt_q, cnt_d;
   // Saturates at TIMEOUT so the count can never wrap.
   always_comb begin
      cnt_d   = clear ? '0 : (enable && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
      expired = (TIMEOUT != 0) && enable && (cnt_q == LAST);
   end
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB4 transfers, one outstanding.
//  PCLK, PRESETn                       : clock, async active-low reset
//  cmd_valid/cmd_ready                 : command handshake (ready only in IDLE)
//  cmd_write/cmd_addr/cmd_wdata/cmd_strb : command payload
//  rsp_valid/rsp_ready                 : response handshake (valid only in RESP)
//  rsp_rdata/rsp_err/rsp_timeout       : read data, PSLVERR-or-timeout, timeout abort
//  apb                                 : APB4 master bus
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH = APB_DATA_WIDTH,
   parameter int TIMEOUT    = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   apb_master_bridge_if.master     apb
);
   state_t                  state_q, state_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
   rsp_t                    rsp_q, rsp_d;
   logic                    timer_clear, timer_en, expired, psel;
   apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (expired)
   );
   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      rsp_d   = rsp_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d = SETUP;
            write_d = cmd_write;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            strb_d  = cmd_strb;
         end
         SETUP: state_d = ACCESS;
         ACCESS: if (apb.PREADY) begin
            // PREADY takes priority over a timeout on the same edge.
            state_d       = RESP;
            rsp_d.rdata   = (write_q || apb.PSLVERR) ? '0 : APB_DATA_WIDTH'(apb.PRDATA);
            rsp_d.err     = apb.PSLVERR;
            rsp_d.timeout = 1'b0;
         end else if (expired) begin
            state_d       = RESP;
            rsp_d.rdata   = '0;
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b1;
         end
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      psel        = (state_q == SETUP) || (state_q == ACCESS);
      timer_clear = (state_q == SETUP);
      timer_en    = (state_q == ACCESS);
      // Gated by PRESETn so cmd_ready is low for the whole reset pulse.
      cmd_ready   = PRESETn && (state_q == IDLE);
      rsp_valid   = (state_q == RESP);
      rsp_rdata   = rsp_valid ? DATA_WIDTH'(rsp_q.rdata) : '0;
      rsp_err     = rsp_valid && rsp_q.err;
      rsp_timeout = rsp_valid && rsp_q.timeout;
      apb.PSEL    = psel;
      apb.PENABLE = (state_q == ACCESS);
      apb.PWRITE  = write_q;
      apb.PADDR   = addr_q;
      apb.PWDATA  = psel ? wdata_q : '0;
      apb.PSTRB   = (psel && write_q) ? strb_q : '0;
   end
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         rsp_q   <= rsp_d;
      end
   end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for apb_master_bridge with a behavioural APB slave.
module tb_apb_master_bridge;
   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_strb = '0;
   logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   int checks = 0, failures = 0;
   logic [33:0] exp_q[$];
   int ready_at = 5;
   int acnt;
   int acc_len = 0, last_len = 0;
   logic [31:0] mem [16] = '{default: 32'h0};

   always #5 PCLK = ~PCLK;

   apb_master_bridge_if bus ();

   apb_master_bridge dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .apb         (bus.master)
   );

   // Slave: PREADY on ACCESS cycle ready_at (0 = never); error for addr[7:6]==11.
   assign bus.PREADY  = bus.PSEL && bus.PENABLE && (ready_at != 0) && (acnt == ready_at - 1);
   assign bus.PSLVERR = bus.PREADY && (bus.PADDR[7:6] == 2'b11);
   assign bus.PRDATA  = mem[bus.PADDR[5:2]];

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) acnt <= 0;
      else begin
         acnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? acnt + 1 : 0;
         if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && !bus.PSLVERR)
            for (int b = 0; b < 4; b++)
               if (bus.PSTRB[b]) mem[bus.PADDR[5:2]][8*b +: 8] <= bus.PWDATA[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return {45'h0, cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
              bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB};
   endfunction

   // Monitor: response scoreboard plus APB phase/stability checks.
   initial begin
      logic        prev_psel, prev_pen;
      logic [44:0] prev_bus;
      prev_psel = 0; prev_pen = 0; prev_bus = '0;
      forever begin
         @(negedge PCLK);
         if (!PRESETn) begin
            prev_psel = 0; prev_pen = 0; acc_len = 0;
            continue;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected actual=%0h required=none", {rsp_rdata, rsp_err, rsp_timeout});
            end else chk("rsp", {rsp_rdata, rsp_err, rsp_timeout}, exp_q.pop_front());
         end
         if (bus.PSEL && !bus.PWRITE) chk("pstrb_read", bus.PSTRB, 0);
         if (!bus.PSEL) chk("idle_zero", {bus.PENABLE, bus.PWDATA, bus.PSTRB}, 0);
         if (prev_psel && !prev_pen) chk("setup_one_cycle", {bus.PSEL, bus.PENABLE}, 2'b11);
         if (bus.PENABLE && !prev_pen) chk("setup_before_access", {prev_psel, prev_pen}, 2'b10);
         if (bus.PENABLE && prev_pen)
            chk("access_stable", {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB}, prev_bus);
         if (bus.PSEL && bus.PENABLE) acc_len++;
         else if (acc_len > 0) begin
            last_len = acc_len;
            acc_len  = 0;
         end
         prev_psel = bus.PSEL;
         prev_pen  = bus.PENABLE;
         prev_bus  = {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB};
      end
   end

   task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int budget = 200;
      do begin
         @(posedge PCLK); #1;
         budget--;
      end while (!cmd_ready && budget > 0);
      if (!cmd_ready) begin
         checks++; failures++;
         $display("FAIL cmd_ready_wait actual=0 required=1");
      end
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
      @(posedge PCLK); #1;
      cmd_valid = 0;
   endtask

   task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic ee, input logic et);
      exp_q.push_back({er, ee, et});
      issue(w, a, d, s);
   endtask

   task automatic wait_idle();
      int budget = 200;
      while ((exp_q.size() != 0 || !cmd_ready) && budget > 0) begin
         @(posedge PCLK); #1;
         budget--;
      end
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL rsp_wait actual=pending%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      logic [33:0] snap;
      int budget;
      PRESETn = 1;
      #1 PRESETn = 0;
      #1 chk("reset_outs", outs(), 0);
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1;
      @(posedge PCLK); #1;
      chk("ready_after_reset", {cmd_ready, rsp_valid, bus.PSEL}, 3'b100);

      send(1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);           wait_idle();
      chk("wait_len_mem", last_len, 5);
      send(0, 8'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0);           wait_idle();
      send(1, 8'h10, 32'h0000AA00, 4'b0010, 32'h0, 0, 0);        wait_idle();
      send(0, 8'h10, 32'h0, 4'h0, 32'hDEADAAEF, 0, 0);           wait_idle();
      send(0, 8'hC5, 32'h0, 4'h0, 32'h0, 1, 0);                  wait_idle();
      send(1, 8'h14, 32'h12345678, 4'b1001, 32'h0, 0, 0);        wait_idle();
      send(0, 8'h14, 32'h0, 4'h0, 32'h12000078, 0, 0);           wait_idle();
      send(1, 8'hC4, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0);           wait_idle();

      ready_at = 0;
      send(0, 8'h10, 32'h0, 4'h0, 32'h0, 1, 1);                  wait_idle();
      chk("timeout_len", last_len, 16);
      ready_at = 16;
      send(0, 8'h10, 32'h0, 4'h0, 32'hDEADAAEF, 0, 0);           wait_idle();
      chk("ready_at_limit_len", last_len, 16);
      send(1, 8'h18, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0);           wait_idle();
      ready_at = 5;
      send(0, 8'h18, 32'h0, 4'h0, 32'hCAFEF00D, 0, 0);           wait_idle();

      ready_at = 0;
      issue(0, 8'h10, 32'h0, 4'h0);
      repeat (3) @(posedge PCLK);
      #1 chk("in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
      PRESETn = 0;
      #1 chk("reset_mid_outs", outs(), 0);
      repeat (2) @(posedge PCLK);
      #1 chk("reset_hold_outs", outs(), 0);
      ready_at = 5;
      PRESETn = 1;
      @(posedge PCLK); #1;
      chk("ready_after_mid_reset", {cmd_ready, rsp_valid, bus.PSEL}, 3'b100);
      repeat (5) @(posedge PCLK);
      #1 chk("no_rsp_after_reset", {rsp_valid, cmd_ready}, 2'b01);

      rsp_ready = 0;
      send(0, 8'h14, 32'h0, 4'h0, 32'h12000078, 0, 0);
      budget = 50;
      while (!rsp_valid && budget > 0) begin
         @(posedge PCLK); #1;
         budget--;
      end
      chk("hold_reached", rsp_valid, 1);
      snap = {rsp_rdata, rsp_err, rsp_timeout};
      for (int i = 0; i < 5; i++) begin
         @(posedge PCLK); #1;
         chk("hold_valid", {rsp_valid, cmd_ready}, 2'b10);
         chk("hold_stable", {rsp_rdata, rsp_err, rsp_timeout}, snap);
      end
      rsp_ready = 1;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
